// File: rtl/dom1_rnd_sched.sv
// Round scheduler and fresh-randomness FIFO for the DOM1 Skinny TBC datapath.
// Optional macro DOM1_RNDSCHED_STALLCNT_EN adds a saturating stall_cnt output.
//
// state | meaning
// IDLE  | waiting for start; FIFO may prefetch
// RUN   | one round per cycle while a fresh word is buffered
// FIN   | one-cycle done pulse, then back to IDLE
module dom1_rnd_sched #(
    parameter int RW     = 48,
    parameter int DEPTH  = 4,
    parameter int ROUNDS = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] rdi_data,
    input  logic          rdi_valid,
    output logic          rdi_ready,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          tbcen,
    output logic [RW-1:0] rnd,
    output logic [5:0]    rnd_cnst,
    output logic          done
`ifdef DOM1_RNDSCHED_STALLCNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_nxt;
    logic            full_q;
    logic            empty;
    logic            push, pop;
    logic [CW-1:0]   round_cnt;
    logic [5:0]      rc;
    logic            last_round;

    assign empty      = (count == '0);
    assign rdi_ready  = !full_q;
    // A full FIFO refuses pushes even when a pop frees a slot this cycle.
    assign push       = rdi_valid && !full_q;
    assign pop        = tbcen;
    assign last_round = (round_cnt == CW'(ROUNDS - 1));

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count  <= count_nxt;
            full_q <= (count_nxt == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rdi_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        tbcen     = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (!empty) begin
                    tbcen = 1'b1;
                    if (last_round) state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                busy      = 1'b1;
                done      = !abort;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counter and constant only advance on an actual round; stalls freeze them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_cnt <= '0;
            rc        <= 6'h01;
        end else if (state != S_RUN || abort) begin
            round_cnt <= '0;
            rc        <= 6'h01;
        end else if (tbcen) begin
            round_cnt <= round_cnt + CW'(1);
            rc        <= {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
        end
    end

    assign rnd_cnst = rc;
    assign rnd      = tbcen ? mem[rd_ptr] : '0;

`ifdef DOM1_RNDSCHED_STALLCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == S_RUN && empty && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dom1_rnd_sched.sv
// Directed bench for dom1_rnd_sched: fill/backpressure, full run, stall, abort,
// start filtering and asynchronous reset, with a background randomness feeder.
module tb_dom1_rnd_sched;
    localparam int RW = 48;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [RW-1:0] rdi_data = '0;
    logic          rdi_valid = 1'b0;
    logic          rdi_ready;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, tbcen, done;
    logic [RW-1:0] rnd;
    logic [5:0]    rnd_cnst;
`ifdef DOM1_RNDSCHED_STALLCNT_EN
    logic [15:0]   stall_cnt;
`endif

    int   compared = 0;
    int   mismatched = 0;
    int   push_idx = 0;
    int   cons_idx = 0;
    int   feed_limit = 0;
    logic feed_en = 1'b0;
    logic acc;
    logic [5:0] rc_exp;
    logic [5:0] rc_tbl [8] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B};

    dom1_rnd_sched #(.RW(RW), .DEPTH(4), .ROUNDS(40)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdi_data  (rdi_data),
        .rdi_valid (rdi_valid),
        .rdi_ready (rdi_ready),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .tbcen     (tbcen),
        .rnd       (rnd),
        .rnd_cnst  (rnd_cnst),
        .done      (done)
`ifdef DOM1_RNDSCHED_STALLCNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    function automatic logic [RW-1:0] word(input int i);
        logic [15:0] lo;
        lo = i[15:0];
        return {16'hC0DE, lo, ~lo};
    endfunction

    // Offers words in order; push_idx counts handshakes seen by the bench.
    initial begin
        forever begin
            @(negedge clk);
            acc = rdi_valid && rdi_ready && rst;
            @(posedge clk);
            #1;
            if (acc && rst) push_idx++;
            rdi_valid = feed_en && (push_idx < feed_limit);
            rdi_data  = rdi_valid ? word(push_idx) : '0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic test_reset();
        @(negedge clk);
        compared += 6;
        if (rdi_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b want 1", rdi_ready); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (tbcen !== 1'b0) begin mismatched++; $display("FAIL rst_tbcen: got %b want 0", tbcen); end
        if (rnd !== '0) begin mismatched++; $display("FAIL rst_rnd: got %h want 0", rnd); end
        if (rnd_cnst !== 6'h01) begin mismatched++; $display("FAIL rst_rc: got %h want 01", rnd_cnst); end
        if (done !== 1'b0) begin mismatched++; $display("FAIL rst_done: got %b want 0", done); end
        #2 rst = 1'b1;
        feed_limit = 6;
        feed_en = 1'b1;
        repeat (8) @(negedge clk);
        compared += 5;
        if (push_idx != 4) begin mismatched++; $display("FAIL fill_accepts: got %0d want 4", push_idx); end
        if (rdi_ready !== 1'b0) begin mismatched++; $display("FAIL fill_ready: got %b want 0", rdi_ready); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL fill_busy: got %b want 0", busy); end
        if (tbcen !== 1'b0) begin mismatched++; $display("FAIL fill_tbcen: got %b want 0", tbcen); end
        if (rnd !== '0) begin mismatched++; $display("FAIL fill_rnd: got %h want 0", rnd); end
    endtask

    task automatic test_stall();
        logic exp_tbc;
        feed_en = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #2;
        cons_idx   = push_idx;
        feed_limit = push_idx + 2;
        @(negedge clk);
        #2 rst = 1'b1;
        feed_en = 1'b1;
        repeat (5) @(negedge clk);
        compared++;
        if (rdi_ready !== 1'b1) begin mismatched++; $display("FAIL stall_prefill_ready: got %b want 1", rdi_ready); end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        rc_exp = 6'h01;
        for (int c = 1; c <= 47; c++) begin
            @(negedge clk);
            exp_tbc = (c <= 2) || (c >= 8 && c <= 45);
            compared += 2;
            if (tbcen !== exp_tbc) begin mismatched++; $display("FAIL stall_tbcen c=%0d: got %b want %b", c, tbcen, exp_tbc); end
            if (done !== (c == 46)) begin mismatched++; $display("FAIL stall_done c=%0d: got %b want %b", c, done, c == 46); end
            if (exp_tbc) begin
                compared += 2;
                if (rnd !== word(cons_idx)) begin mismatched++; $display("FAIL stall_rnd c=%0d: got %h want %h", c, rnd, word(cons_idx)); end
                if (rnd_cnst !== rc_exp) begin mismatched++; $display("FAIL stall_rc c=%0d: got %h want %h", c, rnd_cnst, rc_exp); end
                cons_idx++;
                rc_exp = {rc_exp[4:0], rc_exp[5] ^ rc_exp[4] ^ 1'b1};
            end else if (c >= 3 && c <= 7) begin
                compared += 2;
                if (rnd !== '0) begin mismatched++; $display("FAIL stall_gap_rnd c=%0d: got %h want 0", c, rnd); end
                if (rnd_cnst !== 6'h07) begin mismatched++; $display("FAIL stall_gap_rc c=%0d: got %h want 07", c, rnd_cnst); end
            end
            if (c == 6) feed_limit = 1000;
            if (c == 47) begin
                compared++;
                if (busy !== 1'b0) begin mismatched++; $display("FAIL stall_busy_end: got %b want 0", busy); end
`ifdef DOM1_RNDSCHED_STALLCNT_EN
                compared++;
                if (stall_cnt !== 16'd5) begin mismatched++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt); end
`endif
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full_run(input bit with_restart);
        if (with_restart) begin
            repeat (6) @(negedge clk);
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        rc_exp = 6'h01;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            if (c <= 40) begin
                compared += 4;
                if (tbcen !== 1'b1) begin mismatched++; $display("FAIL run_tbcen c=%0d: got %b want 1", c, tbcen); end
                if (done !== 1'b0) begin mismatched++; $display("FAIL run_done_early c=%0d: got %b want 0", c, done); end
                if (rnd !== word(cons_idx)) begin mismatched++; $display("FAIL run_rnd c=%0d: got %h want %h", c, rnd, word(cons_idx)); end
                if (rnd_cnst !== ((c <= 8) ? rc_tbl[c-1] : rc_exp)) begin
                    mismatched++;
                    $display("FAIL run_rc c=%0d: got %h want %h", c, rnd_cnst, (c <= 8) ? rc_tbl[c-1] : rc_exp);
                end
                cons_idx++;
                rc_exp = {rc_exp[4:0], rc_exp[5] ^ rc_exp[4] ^ 1'b1};
            end else if (c == 41) begin
                compared += 3;
                if (done !== 1'b1) begin mismatched++; $display("FAIL run_done: got %b want 1", done); end
                if (busy !== 1'b1) begin mismatched++; $display("FAIL run_fin_busy: got %b want 1", busy); end
                if (tbcen !== 1'b0) begin mismatched++; $display("FAIL run_fin_tbcen: got %b want 0", tbcen); end
            end else begin
                compared += 2;
                if (busy !== 1'b0) begin mismatched++; $display("FAIL run_idle_busy: got %b want 0", busy); end
                if (done !== 1'b0) begin mismatched++; $display("FAIL run_idle_done: got %b want 0", done); end
            end
            @(posedge clk); #1;
            // A start pulse mid-run must not restart the invocation.
            start = with_restart && (c == 9);
        end
        start = 1'b0;
    endtask

    task automatic test_abort();
        repeat (6) @(negedge clk);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c <= 10) begin
                compared += 2;
                if (tbcen !== 1'b1) begin mismatched++; $display("FAIL abort_tbcen c=%0d: got %b want 1", c, tbcen); end
                if (rnd !== word(cons_idx)) begin mismatched++; $display("FAIL abort_rnd c=%0d: got %h want %h", c, rnd, word(cons_idx)); end
                cons_idx++;
            end else if (c == 11) begin
                compared += 3;
                if (tbcen !== 1'b0) begin mismatched++; $display("FAIL abort_cycle_tbcen: got %b want 0", tbcen); end
                if (rnd !== '0) begin mismatched++; $display("FAIL abort_cycle_rnd: got %h want 0", rnd); end
                if (busy !== 1'b1) begin mismatched++; $display("FAIL abort_cycle_busy: got %b want 1", busy); end
            end else begin
                compared += 4;
                if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_idle_busy c=%0d: got %b want 0", c, busy); end
                if (done !== 1'b0) begin mismatched++; $display("FAIL abort_no_done c=%0d: got %b want 0", c, done); end
                if (tbcen !== 1'b0) begin mismatched++; $display("FAIL abort_idle_tbcen c=%0d: got %b want 0", c, tbcen); end
                if (rnd_cnst !== 6'h01) begin mismatched++; $display("FAIL abort_rc c=%0d: got %h want 01", c, rnd_cnst); end
            end
            if (c < 14) begin
                @(posedge clk); #1;
                abort = (c == 10);
            end
        end
        // start and abort together in IDLE: start wins.
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL startabort_idle_busy: got %b want 0", busy); end
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        test_full_run(1'b0);
    endtask

    task automatic test_async_reset();
        repeat (4) @(negedge clk);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            compared++;
            if (tbcen !== 1'b1 || rnd !== word(cons_idx)) begin
                mismatched++;
                $display("FAIL ares_run c=%0d: got tbcen=%b rnd=%h want 1 %h", c, tbcen, rnd, word(cons_idx));
            end
            cons_idx++;
            if (c < 20) begin @(posedge clk); #1; end
        end
        #2 rst = 1'b0;
        feed_en = 1'b0;
        #1;
        compared += 6;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL ares_busy: got %b want 0", busy); end
        if (tbcen !== 1'b0) begin mismatched++; $display("FAIL ares_tbcen: got %b want 0", tbcen); end
        if (rnd !== '0) begin mismatched++; $display("FAIL ares_rnd: got %h want 0", rnd); end
        if (rnd_cnst !== 6'h01) begin mismatched++; $display("FAIL ares_rc: got %h want 01", rnd_cnst); end
        if (done !== 1'b0) begin mismatched++; $display("FAIL ares_done: got %b want 0", done); end
        if (rdi_ready !== 1'b1) begin mismatched++; $display("FAIL ares_ready: got %b want 1", rdi_ready); end
        @(posedge clk); #2;
        cons_idx = push_idx;
        @(negedge clk); #2 rst = 1'b1;
        #1;
        compared++;
        if (rdi_ready !== 1'b1) begin mismatched++; $display("FAIL ares_release_ready: got %b want 1", rdi_ready); end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            compared += 2;
            if (busy !== 1'b1) begin mismatched++; $display("FAIL ares_empty_busy c=%0d: got %b want 1", c, busy); end
            if (tbcen !== 1'b0) begin mismatched++; $display("FAIL ares_empty_tbcen c=%0d: got %b want 0", c, tbcen); end
            if (c == 3) feed_en = 1'b1;
            @(posedge clk); #1;
        end
        @(negedge clk);
        compared += 3;
        if (tbcen !== 1'b1) begin mismatched++; $display("FAIL ares_resume_tbcen: got %b want 1", tbcen); end
        if (rnd !== word(cons_idx)) begin mismatched++; $display("FAIL ares_resume_rnd: got %h want %h", rnd, word(cons_idx)); end
        if (rnd_cnst !== 6'h01) begin mismatched++; $display("FAIL ares_resume_rc: got %h want 01", rnd_cnst); end
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL ares_final_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_full_run(1'b1);
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dom1_rnd_sched.md
Name: dom1_rnd_sched

Overview:
- Round scheduler and fresh-randomness manager for the DOM1 Skinny TBC datapath.
- Buffers 48-bit masking randomness from the rdi stream in a small FIFO.
- On a start pulse from the control unit, sequences ROUNDS TBC rounds. Each round consumes exactly one random word and advances the Skinny round constant.
- Stalls (holds tbcen low) whenever no fresh word is available, so randomness is never reused or skipped.

Parameters:
- RW, 48, width of one randomness word (matches rdi_data).
- DEPTH, 4, FIFO depth in words (power of two, >=2).
- ROUNDS, 40, TBC rounds per invocation (Skinny-128-384+).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- rdi_data  in  RW  fresh random word.
- rdi_valid  in  1  rdi_data valid.
- rdi_ready  out  1  word accepted when rdi_valid & rdi_ready.
- start  in  1  single-cycle request to run one TBC invocation.
- abort  in  1  synchronous abandon of the current invocation.
- busy  out  1  invocation in progress.
- tbcen  out  1  datapath performs one round this cycle.
- rnd  out  RW  randomness for the current round.
- rnd_cnst  out  6  Skinny round constant for the current round.
- done  out  1  single-cycle pulse after the last round.

Behaviour:
- Reset values: rdi_ready=1, busy=0, tbcen=0, rnd=0, rnd_cnst=6'h01, done=0. FIFO empty, state IDLE, round counter 0.
- Reset is asynchronous and may arrive mid-invocation. All state clears and buffered words are discarded.
- FIFO:
  - rdi_ready = !full, registered from occupancy.
  - Push accepted in any state, including IDLE (prefetch).
  - Pop only when tbcen=1.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - No bypass: a word pushed in cycle t can be consumed at t+1 at the earliest.
  - When full, no push is accepted even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
- States: IDLE, RUN, FIN.
- IDLE:
  - busy=0.
  - start=1 -> RUN; round counter <= 0; rc <= 6'h01.
- RUN:
  - busy=1.
  - tbcen = !empty & !abort (combinational).
  - When tbcen=1: rnd = FIFO head; pop; counter++; rc <= {rc[4:0], rc[5]^rc[4]^1}.
  - rnd_cnst = rc, so the sequence is 01,03,07,0F,1F,3E,3D,3B,...
  - If tbcen=1 and counter==ROUNDS-1 -> FIN.
- FIN:
  - done=1 and busy=1 for one cycle, then -> IDLE.
  - rc resets to 6'h01.
- rnd is forced to all-zero whenever tbcen=0, so no stale randomness reaches the shares.
- start while busy is ignored. start and abort together in IDLE: start wins.
- abort in RUN or FIN:
  - Next state IDLE, no done pulse, counter and rc reset.
  - FIFO contents are retained. No pop happens in the abort cycle.
- Stall: an empty FIFO in RUN holds counter, rc and state; the datapath must hold its state while tbcen=0.
- Latency with a pre-filled FIFO:
  - start at cycle t gives tbcen high for cycles t+1..t+ROUNDS.
  - done at t+ROUNDS+1.
  - busy low at t+ROUNDS+2.

Optional Feature:
- Macro: DOM1_RNDSCHED_STALLCNT_EN.
- Defined:
  - Adds output stall_cnt[15:0].
  - Counts RUN cycles with empty FIFO. Saturates at 16'hFFFF.
  - Clears on start accepted in IDLE and on reset.
  - Holds its value after done or abort.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, DEPTH=4: push 4 words with rdi_valid=1 continuously -> rdi_ready drops after the 4th accept; busy=0; tbcen=0; rnd=0.
- FIFO kept fed; start pulse -> 40 consecutive tbcen cycles; rnd_cnst sequence starts 01,03,07,0F,1F,3E,3D,3B; rnd equals the pushed words in order; done pulse 41 cycles after start.
- Pre-fill 2 words; start; supply the 3rd word 5 cycles late -> tbcen low for the gap; counter and rnd_cnst frozen at 03→07 boundary; resumes with the 3rd word; done still after exactly 40 tbcen cycles; with DOM1_RNDSCHED_STALLCNT_EN, stall_cnt reflects the gap cycles.
- Abort after round 10 -> IDLE next cycle, no done; remaining FIFO words kept; next start rnd_cnst restarts at 01 and consumes the next unconsumed word.
- Start asserted during RUN -> ignored, no restart; start+abort simultaneously in IDLE -> invocation begins.
- rst driven low at round 20 -> all outputs at reset values immediately (asynchronously); FIFO empty; rdi_ready=1 after release.
